// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared control encodings for the instruction-fetch stage:
//   - NPC_* : next-PC operation codes driven by ID (id_npc_op)
//   - RESET_PC : word address of the first fetch (byte 0x3000)
//   - state_t : fetch FSM state encoding
//   - sext16 : 16-to-30 bit sign extension used by the branch adder
// Optional feature macro used by the fetch stage: IF_DELAY_SLOT_EN.
// -----------------------------------------------------------------------------
package if_stage_pkg;

   localparam logic [1:0] NPC_NORMAL = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_RF     = 2'b11;

   localparam logic [29:0] RESET_PC = 30'h0000_0C00;

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   function automatic logic [29:0] sext16(input logic [15:0] imm);
      return {{14{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Bundles every non-clock signal of the fetch stage.
//   ID control   : stall, id_pc_sel, id_npc_op, id_pc, id_imm16,
//                  id_instr_index, id_rs_data
//   Instr memory : imem_req, imem_addr (out), imem_rdata, imem_valid (in)
//   IF/ID regs   : if_id_pc, if_id_instr, if_id_valid
//   Debug        : dbg_state (current fetch FSM state)
// Handshake: imem_req=1 means imem_addr is a live request; the memory raises
// imem_valid in any cycle where imem_rdata is the word at the current
// imem_addr. There is no back-pressure on the memory side: a request may be
// abandoned (address changed) while imem_valid=0.
// Modports: master = the fetch stage, slave = its environment.
// -----------------------------------------------------------------------------
interface if_stage_if;
   import if_stage_pkg::*;

   logic        stall;
   logic        id_pc_sel;
   logic [1:0]  id_npc_op;
   logic [29:0] id_pc;
   logic [15:0] id_imm16;
   logic [25:0] id_instr_index;
   logic [31:0] id_rs_data;

   logic        imem_req;
   logic [29:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;

   logic [29:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;

   state_t      dbg_state;

   modport master (
      input  stall, id_pc_sel, id_npc_op, id_pc, id_imm16, id_instr_index,
             id_rs_data, imem_rdata, imem_valid,
      output imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid,
             dbg_state
   );

   modport slave (
      output stall, id_pc_sel, id_npc_op, id_pc, id_imm16, id_instr_index,
             id_rs_data, imem_rdata, imem_valid,
      input  imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid,
             dbg_state
   );

endinterface

// File: rtl/if_stage_npc_calc.sv
// -----------------------------------------------------------------------------
// npc_calc
// Purely combinational redirect-target generator (word addresses).
// Ports:
//   i_npc_op        : NPC_NORMAL / NPC_BRANCH / NPC_JUMP / NPC_RF
//   i_pc_q          : current fetch PC
//   i_id_pc         : PC of the instruction in ID
//   i_id_imm16      : branch offset (words)
//   i_id_instr_index: jump index
//   i_id_rs_word    : register operand, already reduced to bits [31:2]
//   o_target        : selected target
// -----------------------------------------------------------------------------
module npc_calc
   import if_stage_pkg::*;
(
   input  logic [1:0]  i_npc_op,
   input  logic [29:0] i_pc_q,
   input  logic [29:0] i_id_pc,
   input  logic [15:0] i_id_imm16,
   input  logic [25:0] i_id_instr_index,
   input  logic [29:0] i_id_rs_word,
   output logic [29:0] o_target
);

   logic [29:0] w_id_pc_plus1;

   assign w_id_pc_plus1 = i_id_pc + 30'd1;

   always_comb begin
      o_target = i_pc_q + 30'd1;
      case (i_npc_op)
         NPC_BRANCH: o_target = w_id_pc_plus1 + sext16(i_id_imm16);
         // Jump stays inside the 256 MB region of the delay-slot PC.
         NPC_JUMP:   o_target = {w_id_pc_plus1[29:26], i_id_instr_index};
         NPC_RF:     o_target = i_id_rs_word;
         default:    o_target = i_pc_q + 30'd1;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: fetches one word per cycle from instruction
// memory, buffers it across ID stalls and applies redirects from ID.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : if_stage_if.master (ID control, instruction memory, IF/ID regs,
//           debug FSM state)
// Configuration macro: IF_DELAY_SLOT_EN
//   defined   - MIPS delay slot: the word fetched alongside a redirect is
//               delivered valid; a redirect seen without a delivery is parked
//               and takes effect after the next delivery.
//   undefined - the word fetched alongside a redirect is squashed, and a
//               redirect without a delivery retargets the PC at once.
// -----------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   if_stage_if.master    bus
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [29:0] r_pc;
   logic [31:0] r_buf;
   logic [29:0] r_if_id_pc;
   logic [31:0] r_if_id_instr;
   logic        r_if_id_valid;

   logic        w_req;
   logic        w_deliver;
   logic        w_bubble;
   logic        w_capture;
   logic [31:0] w_word;
   logic        w_redirect;
   logic [29:0] w_target;
   logic        w_unused_rs;

`ifdef IF_DELAY_SLOT_EN
   logic [29:0] r_redir;
   logic        r_redir_pend;
`endif

   // Byte offset bits of the register target are meaningless for fetch.
   assign w_unused_rs = &{1'b0, bus.id_rs_data[1:0]};

   // Stall freezes the whole stage, so a redirect under stall is ignored.
   assign w_redirect = ~bus.id_pc_sel & ~bus.stall;

   npc_calc u_npc_calc (
      .i_npc_op         (bus.id_npc_op),
      .i_pc_q           (r_pc),
      .i_id_pc          (bus.id_pc),
      .i_id_imm16       (bus.id_imm16),
      .i_id_instr_index (bus.id_instr_index),
      .i_id_rs_word     (bus.id_rs_data[31:2]),
      .o_target         (w_target)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_BOOT;
      else        r_state <= w_state_nxt;
   end

   // FSM next state and per-cycle actions
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_deliver   = 1'b0;
      w_bubble    = 1'b0;
      w_capture   = 1'b0;
      w_word      = bus.imem_rdata;
      case (r_state)
         ST_BOOT: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            w_req = 1'b1;
            if (bus.imem_valid) begin
               if (bus.stall) begin
                  w_capture   = 1'b1;
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_deliver = 1'b1;
               end
            end else if (!bus.stall) begin
               w_bubble = 1'b1;
            end
         end
         ST_HOLD: begin
            w_word = r_buf;
            if (!bus.stall) begin
               w_deliver   = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
   end

   // Datapath: PC, stall buffer, IF/ID register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_buf         <= 32'd0;
         r_if_id_pc    <= 30'd0;
         r_if_id_instr <= 32'd0;
         r_if_id_valid <= 1'b0;
`ifdef IF_DELAY_SLOT_EN
         r_redir       <= 30'd0;
         r_redir_pend  <= 1'b0;
`endif
      end else begin
         if (w_capture) r_buf <= bus.imem_rdata;
`ifdef IF_DELAY_SLOT_EN
         if (w_deliver) begin
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= w_word;
            r_if_id_valid <= 1'b1;
         end else if (w_bubble) begin
            r_if_id_instr <= 32'd0;
            r_if_id_valid <= 1'b0;
         end
         if (w_redirect) begin
            if (w_deliver) begin
               // The delivered word is the delay slot; a newer redirect
               // supersedes any parked one.
               r_pc         <= w_target;
               r_redir_pend <= 1'b0;
            end else begin
               // No delay slot fetched yet: park the target until it is.
               r_redir      <= w_target;
               r_redir_pend <= 1'b1;
            end
         end else if (w_deliver) begin
            if (r_redir_pend) begin
               r_pc         <= r_redir;
               r_redir_pend <= 1'b0;
            end else begin
               r_pc <= r_pc + 30'd1;
            end
         end
`else
         if (w_deliver && !w_redirect) begin
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= w_word;
            r_if_id_valid <= 1'b1;
         end else if (w_deliver || w_bubble) begin
            // Word fetched down the wrong path is squashed.
            r_if_id_instr <= 32'd0;
            r_if_id_valid <= 1'b0;
         end
         if (w_redirect)     r_pc <= w_target;
         else if (w_deliver) r_pc <= r_pc + 30'd1;
`endif
      end
   end

   assign bus.imem_req    = w_req & rst_n;
   assign bus.imem_addr   = r_pc;
   assign bus.if_id_pc    = r_if_id_pc;
   assign bus.if_id_instr = r_if_id_instr;
   assign bus.if_id_valid = r_if_id_valid;
   assign bus.dbg_state   = r_state;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have ports: clk in 1, clock; rst_n in 1, synchronous active-low reset.
REQ-002 SHALL have ports: stall in 1, hold IF/ID; id_pc_sel in 1, 0 = redirect, 1 = sequential; id_npc_op in 2, redirect kind.
REQ-003 SHALL have ports: id_pc in 30, PC[31:2] of the ID instruction; id_imm16 in 16; id_instr_index in 26; id_rs_data in 32.
REQ-004 SHALL have ports: imem_req out 1; imem_addr out 30; imem_rdata in 32; imem_valid in 1, rdata matches the current imem_addr.
REQ-005 SHALL have ports: if_id_pc out 30; if_id_instr out 32; if_id_valid out 1.
REQ-006 The clock and reset are fixed: one clock, clk; rst_n is synchronous and active-low.

Function
REQ-007 The FSM SHALL have three states.
- BOOT: imem_req=0.
- RUN: imem_req=1, imem_addr=pc_q.
- HOLD: imem_req=0; the fetched word sits in buf_q.
REQ-008 BOOT SHALL move to RUN after exactly one cycle.
REQ-009 RUN SHALL behave as follows.
- imem_valid=1 and stall=0: deliver imem_rdata.
- imem_valid=1 and stall=1: buf_q<=imem_rdata, move to HOLD.
- imem_valid=0 and stall=0: load a bubble.
REQ-010 HOLD with stall=0 SHALL deliver buf_q and move to RUN; HOLD with stall=1 SHALL hold.
REQ-011 Deliver SHALL load if_id_pc<=pc_q, if_id_instr<=word and if_id_valid<=1; bubble SHALL load if_id_valid<=0 and if_id_instr<=0.
REQ-012 With stall=1, the IF/ID outputs and pc_q SHALL hold and redirects SHALL be ignored.
REQ-013 A redirect SHALL be consumed in any cycle with id_pc_sel=0 and stall=0.
REQ-014 The redirect target SHALL be computed combinationally by id_npc_op.
- BRANCH: id_pc+1+sext(id_imm16), mod 2^30.
- JUMP: {(id_pc+1)[29:26], id_instr_index}.
- RF: id_rs_data[31:2].
- NORMAL: pc_q+1.
REQ-015 Sequential next PC SHALL be pc_q+1 and SHALL wrap from 0x3FFFFFFF to 0.
REQ-016 A delivery without a redirect and without a pending redirect SHALL load pc_q<=pc_q+1.
REQ-017 When a delivery, a consumed redirect and a pending redirect coincide, the redirect behaviour of REQ-023..026 SHALL apply.
REQ-018 imem_addr MAY change while imem_valid=0; the memory SHALL tolerate an abandoned request.

Reset
REQ-019 While rst_n=0 at a clk edge, the block SHALL set: pc_q=0x00000C00 (byte 0x3000), state=BOOT, if_id_valid=0, if_id_instr=0, if_id_pc=0, buf_q=0, redir_pend_q=0.
REQ-020 imem_req SHALL be 0 while in reset and in BOOT.
REQ-021 A reset asserted in HOLD or while a redirect is pending SHALL discard the buffered word and the pending target.

Configuration
REQ-022 Macro IF_DELAY_SLOT_EN SHALL select MIPS branch-delay-slot behaviour.
REQ-023 Defined, redirect coincident with delivery: the delivered word SHALL be loaded valid, and pc_q<=target.
REQ-024 Defined, redirect without delivery: redir_q<=target and redir_pend_q<=1, with pc_q unchanged; the next delivery SHALL set pc_q<=redir_q and clear redir_pend_q.
REQ-025 Undefined, redirect coincident with delivery: a bubble SHALL be loaded and pc_q<=target.
REQ-026 Undefined, redirect without delivery: pc_q<=target immediately; redir_q and redir_pend_q SHALL NOT exist.

Structure
REQ-027 The NPC_NORMAL/BRANCH/JUMP/RF encodings (00/01/10/11), the reset PC constant and the FSM state encoding SHALL live in the shared control encoding package.
REQ-028 Target computation SHALL be one sub-module, npc_calc, which is purely combinational.

Verification
REQ-029 Reset release, imem_valid=1 always, stall=0: imem_req=0 for one cycle, then if_id_pc = 0xC00, 0xC01, 0xC02 on consecutive cycles.
REQ-030 stall=1 for 3 cycles while imem_valid=1 at pc 0xC05: HOLD is entered and imem_req=0; on release the buffered word is delivered at if_id_pc=0xC05, followed by 0xC06.
REQ-031 BRANCH with id_pc=0xC04, imm=0xFFFE and delivery at 0xC05: with the macro, 0xC05 is delivered valid then 0xC03; without it, a bubble then 0xC03.
REQ-032 JUMP with imem_valid=0 at the redirect: with the macro, pending is set and the target is fetched after the delay slot; without it, imem_addr equals the target on the next cycle.
REQ-033 RF with id_rs_data=0x00400010 gives next if_id_pc=0x00100004; pc_q=0x3FFFFFFF sequential wraps to 0.
REQ-034 Reset asserted in HOLD with a pending redirect: all outputs take their REQ-019 values at the next edge.
